sdram_avs_responder: RTL and testbench
======================================

// Module: sdram_avs_responder
// PURPOSE
//  Avalon-MM style slave that answers the frame-buffer controller's SDRAM master port (active-low strobes, 24-bit
//  {bank1,row[12:0],bank0,col[8:0]} address, 16-bit data). Backs transfers with on-chip RAM and emulates SDRAM
//  timing (init, row activate, periodic refresh) via a registered waitrequest. Used as drop-in SDRAM stand-in
//  for bring-up and as the responder in controller-level simulation.
// PARAMETERS
//  MEM_AW      12   RAM index width; word index = avm_addr[MEM_AW-1:0] (upper bits ignored for storage)
//  RD_LAT      3    clocks from read-accept edge to avs_rddata_vld; legal 1..8
//  TRCD        2    stall cycles after an accepted access whose row key differs from open row (or none open)
//  REF_PERIOD  780  clocks between refresh requests
//  REF_CYC     8    stall cycles per refresh
//  INIT_CYC    16   stall cycles after reset release
// PORTS
//  clk             in   1   single clock domain
//  rst             in   1   asynchronous, active-high reset
//  avm_write       in   1   write strobe, active LOW
//  avm_read        in   1   read strobe, active LOW
//  avm_addr        in   24  word address; row key = avm_addr[23:9]
//  avm_wrdata      in   16  write data
//  avs_rddata      out  16  read data, meaningful only with avs_rddata_vld
//  avs_rddata_vld  out  1   one pulse per accepted read
//  avs_waitrequest out  1   registered; 1 = no transfer accepted this cycle
//  err_both        out  1   1-cycle pulse: both strobes low at an accept cycle
// BEHAVIOUR
//  Reset: avs_waitrequest=1, avs_rddata_vld=0, avs_rddata=0, err_both=0, state=INIT, row_valid=0, pipe cleared,
//   ref counter=0. RAM contents NOT cleared. Reset mid-read drops pending vld pulses.
//  waitrequest is a pure function of registered state (no comb path from strobes; master derives strobes from it).
//  Accept: cycle with avs_waitrequest==0 and (~avm_write | ~avm_read). Write: RAM[idx]<=avm_wrdata at that edge.
//   Read: RAM[idx] sampled at that edge, shifted through RD_LAT-1 further stages; vld exactly RD_LAT clocks later.
//  Both strobes low on accept: write performed, read dropped (no vld), err_both pulses next cycle.
//  Back-to-back write then read same idx: read returns the new data (write-first ordering).
//  Reads accepted every cycle sustain one vld per cycle; pipeline never stalls or drops.
//  FSM (waitrequest=0 only in OPEN):
//   INIT : count INIT_CYC, then OPEN.
//   OPEN : on accept, open row <= row key, row_valid<=1. Next state: REF if ref_due; else ACT if accept was a
//          row miss (row_valid==0 or key differs); else OPEN. No accept and ref_due -> REF.
//   ACT  : stall TRCD cycles, then REF if ref_due else OPEN.
//   REF  : stall REF_CYC cycles, clear row_valid, clear ref_due, then OPEN.
//  ref_due: free-running counter wraps at REF_PERIOD-1 and sets ref_due; counts in all states; ref_due is set-only
//   until REF completes (a second wrap while pending is absorbed, not queued).
//  Miss and ref_due together: REF only (row closed, next access misses again).
//  Stall counters sized for max(INIT_CYC,TRCD,REF_CYC); a count of 0 means no stall cycle for that state.
//  Strobes held low during waitrequest=1 are ignored; master must re-present them (no hidden buffering).
// TESTING
//  T1 reset release: waitrequest=1 for exactly 16 clocks, then 0; rddata_vld stays 0 throughout.
//  T2 write 0x1234 @0x000005, read @0x000005 next accept -> vld exactly 3 clocks after read accept, data 0x1234.
//  T3 row miss: access @0x000200 then @0x000400 -> after each accept waitrequest=1 for 2 clocks; @0x000201 -> no stall.
//  T4 refresh: idle 780 clocks -> waitrequest=1 for 8 clocks; next access @same row still stalls 2 (row closed).
//  T5 both strobes low @0x000010 data 0xBEEF -> err_both pulse, no vld, later read returns 0xBEEF.
//  T6 burst of 512 reads every accept cycle with refresh mid-burst, rst asserted for 1 clk at read #300 ->
//     vld count 300 minus in-flight (RD_LAT), all data correct, waitrequest=1 and vld=0 immediately on rst.

Source files
------------

// File: rtl/sdram_avs_responder.sv
// sdram_avs_responder
//   SDRAM stand-in for the frame-buffer controller's master port. Storage is an
//   on-chip RAM; SDRAM timing (power-up init, row activate, periodic refresh) is
//   emulated purely through a registered waitrequest.
// Ports
//   clk, rst         : clock, asynchronous active-high reset
//   avm_write/read   : active-low strobes from the master
//   avm_addr[23:0]   : {bank1,row[12:0],bank0,col[8:0]} word address
//   avm_wrdata[15:0] : write data
//   avs_rddata[15:0] : read data, qualified by avs_rddata_vld
//   avs_rddata_vld   : one pulse per accepted read, RD_LAT cycles after accept
//   avs_waitrequest  : registered stall, low only while the row is open
//   err_both         : one-cycle pulse when both strobes were low at an accept
module sdram_avs_responder #(
    parameter int MEM_AW     = 12,
    parameter int RD_LAT     = 3,
    parameter int TRCD       = 2,
    parameter int REF_PERIOD = 780,
    parameter int REF_CYC    = 8,
    parameter int INIT_CYC   = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        avm_write,
    input  logic        avm_read,
    input  logic [23:0] avm_addr,
    input  logic [15:0] avm_wrdata,
    output logic [15:0] avs_rddata,
    output logic        avs_rddata_vld,
    output logic        avs_waitrequest,
    output logic        err_both
);

    localparam int MAXC = (INIT_CYC > TRCD) ? ((INIT_CYC > REF_CYC) ? INIT_CYC : REF_CYC)
                                           : ((TRCD > REF_CYC) ? TRCD : REF_CYC);
    localparam int CW = (MAXC < 1) ? 1 : $clog2(MAXC + 1);
    localparam int RW = $clog2(REF_PERIOD + 1);

    // Last count value of each stall; a zero-length stall behaves like length 1
    // for INIT (reset already holds waitrequest) and is bypassed for ACT/REF.
    localparam logic [CW-1:0] INIT_LAST = CW'((INIT_CYC > 0) ? INIT_CYC - 1 : 0);
    localparam logic [CW-1:0] TRCD_LAST = CW'((TRCD > 0) ? TRCD - 1 : 0);
    localparam logic [CW-1:0] REF_LAST  = CW'((REF_CYC > 0) ? REF_CYC - 1 : 0);
    localparam logic [RW-1:0] REF_WRAP  = RW'(REF_PERIOD - 1);

    typedef enum logic [1:0] {S_INIT, S_OPEN, S_ACT, S_REF} state_t;

    state_t              state;
    logic [CW-1:0]       stall_cnt;
    logic [RW-1:0]       ref_cnt;
    logic                ref_due;
    logic                row_valid;
    logic [14:0]         open_row;
    logic [15:0]         mem [2**MEM_AW];
    logic [RD_LAT-1:0]   vld_pipe;
    logic [RD_LAT-1:0][15:0] dat_pipe;

    logic              wr, rd, acc, miss, ref_wrap;
    logic [MEM_AW-1:0] idx;
    logic [14:0]       key;

    assign wr       = ~avm_write;
    assign rd       = ~avm_read;
    // waitrequest is low only in OPEN, so it alone qualifies the accept
    assign acc      = ~avs_waitrequest & (wr | rd);
    assign idx      = avm_addr[MEM_AW-1:0];
    assign key      = avm_addr[23:9];
    assign miss     = ~row_valid | (key != open_row);
    assign ref_wrap = (ref_cnt == REF_WRAP);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= S_INIT;
            stall_cnt       <= '0;
            ref_cnt         <= '0;
            ref_due         <= 1'b0;
            row_valid       <= 1'b0;
            open_row        <= '0;
            avs_waitrequest <= 1'b1;
            err_both        <= 1'b0;
        end else begin
            ref_cnt  <= ref_wrap ? '0 : ref_cnt + 1'b1;
            err_both <= acc & wr & rd;
            case (state)
                S_INIT: begin
                    if (stall_cnt == INIT_LAST) begin
                        state           <= S_OPEN;
                        avs_waitrequest <= 1'b0;
                    end else begin
                        stall_cnt <= stall_cnt + 1'b1;
                    end
                end
                S_OPEN: begin
                    if (acc) begin
                        open_row  <= key;
                        row_valid <= 1'b1;
                    end
                    // refresh outranks a row miss; it closes the row anyway
                    if (ref_due) begin
                        if (REF_CYC == 0) begin
                            row_valid <= 1'b0;
                            ref_due   <= 1'b0;
                        end else begin
                            state           <= S_REF;
                            stall_cnt       <= '0;
                            avs_waitrequest <= 1'b1;
                        end
                    end else if (acc && miss && TRCD != 0) begin
                        state           <= S_ACT;
                        stall_cnt       <= '0;
                        avs_waitrequest <= 1'b1;
                    end
                end
                S_ACT: begin
                    if (stall_cnt == TRCD_LAST) begin
                        stall_cnt <= '0;
                        if (ref_due && REF_CYC != 0) begin
                            state <= S_REF;
                        end else begin
                            state           <= S_OPEN;
                            avs_waitrequest <= 1'b0;
                            if (ref_due) begin
                                row_valid <= 1'b0;
                                ref_due   <= 1'b0;
                            end
                        end
                    end else begin
                        stall_cnt <= stall_cnt + 1'b1;
                    end
                end
                S_REF: begin
                    if (stall_cnt == REF_LAST) begin
                        state           <= S_OPEN;
                        avs_waitrequest <= 1'b0;
                        row_valid       <= 1'b0;
                        ref_due         <= 1'b0;
                    end else begin
                        stall_cnt <= stall_cnt + 1'b1;
                    end
                end
                default: begin
                    state           <= S_INIT;
                    stall_cnt       <= '0;
                    avs_waitrequest <= 1'b1;
                end
            endcase
            // placed last so a wrap on the edge that completes REF is not lost
            if (ref_wrap)
                ref_due <= 1'b1;
        end
    end

    // RAM has no reset: contents survive rst
    always_ff @(posedge clk) begin
        if (acc && wr)
            mem[idx] <= avm_wrdata;
    end

    // Read pipeline: stage 0 samples the RAM at the accept edge. A write on the
    // previous edge has already landed, giving write-first ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe <= '0;
            dat_pipe <= '0;
        end else begin
            vld_pipe[0] <= acc & rd & ~wr;
            dat_pipe[0] <= mem[idx];
            for (int i = 1; i < RD_LAT; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                dat_pipe[i] <= dat_pipe[i-1];
            end
        end
    end

    assign avs_rddata_vld = vld_pipe[RD_LAT-1];
    assign avs_rddata     = dat_pipe[RD_LAT-1];

endmodule

// File: tb/tb_sdram_avs_responder.sv
// tb_sdram_avs_responder
//   Directed bench for sdram_avs_responder. Reads push their expected data and
//   accept cycle into a scoreboard queue; a negedge monitor pops on each vld.
//   Cycle numbering: cyc increments at every posedge; a read accepted in cycle
//   A (waitrequest low with strobe at that negedge) must show vld in cycle A+RD_LAT.
module tb_sdram_avs_responder;

    localparam int RD_LAT     = 3;
    localparam int TRCD       = 2;
    localparam int REF_PERIOD = 780;
    localparam int REF_CYC    = 8;
    localparam int INIT_CYC   = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        avm_write = 1'b1;
    logic        avm_read = 1'b1;
    logic [23:0] avm_addr = '0;
    logic [15:0] avm_wrdata = '0;
    logic [15:0] avs_rddata;
    logic        avs_rddata_vld;
    logic        avs_waitrequest;
    logic        err_both;

    sdram_avs_responder #(
        .MEM_AW(12), .RD_LAT(RD_LAT), .TRCD(TRCD), .REF_PERIOD(REF_PERIOD),
        .REF_CYC(REF_CYC), .INIT_CYC(INIT_CYC)
    ) dut (
        .clk(clk), .rst(rst), .avm_write(avm_write), .avm_read(avm_read),
        .avm_addr(avm_addr), .avm_wrdata(avm_wrdata), .avs_rddata(avs_rddata),
        .avs_rddata_vld(avs_rddata_vld), .avs_waitrequest(avs_waitrequest),
        .err_both(err_both)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic [15:0] data;
    } exp_t;

    exp_t        sbq[$];
    logic [15:0] model [4096];
    int          nvec = 0;
    int          nmis = 0;
    int          vld_cnt = 0;
    int          stall_acc = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nmis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present one transfer from the current negedge until accepted; returns at
    // the negedge following the accept cycle with strobes released.
    task automatic xfer(input bit w, input bit r, input logic [23:0] a, input logic [15:0] d);
        int   n;
        bit   ok;
        exp_t e;
        avm_addr   = a;
        avm_wrdata = d;
        avm_write  = !w;
        avm_read   = !r;
        n  = 0;
        ok = 0;
        while (!ok && n < 2000) begin
            if (!avs_waitrequest) begin
                ok = 1;
                if (w) begin
                    model[a[11:0]] = d;
                end else begin
                    e.cyc  = cyc;
                    e.data = model[a[11:0]];
                    sbq.push_back(e);
                end
            end else begin
                stall_acc++;
            end
            @(negedge clk);
            n++;
        end
        chk("xfer_accepted", 32'(ok), 1);
        avm_write = 1'b1;
        avm_read  = 1'b1;
    endtask

    // Consecutive negedges with waitrequest high, starting at the current one.
    task automatic stall_len(output int n);
        n = 0;
        while (avs_waitrequest && n < 100) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sbq.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("drain", sbq.size(), 0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (sbq.size() > 0 && cyc > sbq[0].cyc + RD_LAT) begin
                chk("vld_missing_latency", cyc - sbq[0].cyc, RD_LAT);
                void'(sbq.pop_front());
            end
            if (avs_rddata_vld) begin
                vld_cnt++;
                chk("vld_expected", 32'(sbq.size() != 0), 1);
                if (sbq.size() != 0) begin
                    e = sbq.pop_front();
                    chk("rd_latency", cyc - e.cyc, RD_LAT);
                    chk("rd_data", avs_rddata, e.data);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, crel, r, inflight;

        // T1: reset values, then exactly INIT_CYC stall cycles after release
        repeat (3) @(negedge clk);
        chk("rst_waitrequest", avs_waitrequest, 1);
        chk("rst_vld", avs_rddata_vld, 0);
        chk("rst_rddata", avs_rddata, 0);
        chk("rst_err_both", err_both, 0);
        rst  = 1'b0;
        crel = cyc;
        stall_len(n);
        chk("init_stall", n, INIT_CYC);
        chk("init_no_vld", vld_cnt, 0);

        // T2: write then read, first access opens a row
        xfer(1, 0, 24'h000005, 16'h1234);
        stall_len(n);
        chk("first_access_trcd", n, TRCD);
        xfer(0, 1, 24'h000005, 16'h0);
        stall_len(n);
        chk("row_hit_no_stall", n, 0);
        drain();

        // T3: row misses stall TRCD, hit in open row does not
        xfer(1, 0, 24'h000200, 16'h0200);
        stall_len(n);
        chk("miss_0x200", n, TRCD);
        xfer(1, 0, 24'h000201, 16'h0201);
        stall_len(n);
        chk("hit_0x201", n, 0);
        xfer(1, 0, 24'h000400, 16'h0400);
        stall_len(n);
        chk("miss_0x400", n, TRCD);

        // T4: idle until the first refresh; its timing and length, row closed
        n = 0;
        while (!avs_waitrequest && n < 1000) begin
            @(negedge clk);
            n++;
        end
        r = cyc;
        chk("refresh_start", r - crel, REF_PERIOD + 1);
        stall_len(n);
        chk("refresh_len", n, REF_CYC);
        xfer(0, 1, 24'h000401, 16'h0);
        stall_len(n);
        chk("post_refresh_row_closed", n, TRCD);
        drain();

        // T5: both strobes -> write happens, read dropped, err pulse
        vld_cnt = 0;
        xfer(1, 1, 24'h000010, 16'hBEEF);
        chk("err_both_pulse", err_both, 1);
        @(negedge clk);
        chk("err_both_one_cycle", err_both, 0);
        repeat (4) @(negedge clk);
        chk("both_no_vld", vld_cnt, 0);
        xfer(0, 1, 24'h000010, 16'h0);
        // back-to-back write then read of the same word returns new data
        xfer(1, 0, 24'h000011, 16'h5A5A);
        xfer(0, 1, 24'h000011, 16'h0);
        drain();

        // T6: fill 512 words, then a continuous read burst with refresh mid-way
        for (int i = 0; i < 512; i++)
            xfer(1, 0, 24'(i), 16'hA000 ^ 16'(i * 7));
        drain();
        n = 0;
        while (((cyc - r) % REF_PERIOD) != REF_PERIOD - 150 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        vld_cnt   = 0;
        stall_acc = 0;
        for (int i = 0; i < 512; i++) begin
            if (i == 300) begin
                #1;
                chk("burst_refresh_seen", 32'(stall_acc >= REF_CYC), 1);
                rst = 1'b1;
                #1;
                chk("rst_async_waitrequest", avs_waitrequest, 1);
                chk("rst_async_vld", avs_rddata_vld, 0);
                inflight = sbq.size();
                chk("inflight_bound", 32'(inflight <= RD_LAT), 1);
                chk("burst_vld_count", vld_cnt + inflight, 300);
                sbq.delete();
                @(negedge clk);
                rst = 1'b0;
            end
            xfer(0, 1, 24'(i), 16'h0);
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
